// File: rtl/fibo_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fibo_seq
//  Description : Iterative Fibonacci / Lucas sequence engine (Moore FSMD)
//                with a start/ready/done_tick handshake, overflow detection
//                with early termination, and abort.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    IW        width of index input i (indices 0 .. 2**IW-1)
//    FW        width of result f and of the internal term registers
//  Ports
//    clk       system clock, rising-edge active
//    rst       synchronous active-low reset (0 = reset)
//    start     start request, sampled only while idle
//    abort     cancel the running computation, honoured only while computing
//    mode      0 = Fibonacci (seeds 0,1), 1 = Lucas (seeds 2,1); latched at start
//    i         sequence index; latched at start
//    ready     high while idle
//    done_tick one-cycle pulse when a result is complete
//    ovf       sticky overflow flag of the last computation
//    f         result / current term, taken straight from the t1 register
// ============================================================================
module fibo_seq #(
    parameter int IW = 5,
    parameter int FW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          mode,
    input  logic [IW-1:0] i,
    output logic          ready,
    output logic          done_tick,
    output logic          ovf,
    output logic [FW-1:0] f
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [FW-1:0] c_seed_lucas = FW'(2);
    localparam logic [FW-1:0] c_one        = FW'(1);
    localparam logic [FW-1:0] c_saturate   = '1;

    state_t        r_state, w_state_next;
    logic [FW-1:0] r_t0, w_t0_next;
    logic [FW-1:0] r_t1, w_t1_next;
    logic [IW-1:0] r_n,  w_n_next;
    logic          r_ovf, w_ovf_next;
    logic [FW:0]   w_sum;

    // One extra bit so the carry out of the term width is visible.
    assign w_sum = {1'b0, r_t0} + {1'b0, r_t1};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_t0    <= '0;
            r_t1    <= '0;
            r_n     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_t0    <= w_t0_next;
            r_t1    <= w_t1_next;
            r_n     <= w_n_next;
            r_ovf   <= w_ovf_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_t0_next    = r_t0;
        w_t1_next    = r_t1;
        w_n_next     = r_n;
        w_ovf_next   = r_ovf;
        ready        = 1'b0;
        done_tick    = 1'b0;

        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_t0_next    = mode ? c_seed_lucas : '0;
                    w_t1_next    = c_one;
                    w_n_next     = i;
                    w_ovf_next   = 1'b0;
                    w_state_next = OP;
                end
            end
            OP: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (r_n == '0) begin
                    // Index 0 asks for the first seed, which lives in t0.
                    w_t1_next    = r_t0;
                    w_state_next = DONE;
                end else if (r_n == IW'(1)) begin
                    w_state_next = DONE;
                end else if (w_sum[FW]) begin
                    // Later terms can only be larger, so stop at the first carry.
                    w_t1_next    = c_saturate;
                    w_ovf_next   = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_t1_next = w_sum[FW-1:0];
                    w_t0_next = r_t1;
                    w_n_next  = r_n - 1'b1;
                end
            end
            DONE: begin
                done_tick    = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign f   = r_t1;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fibo_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fibo_seq
//  Description : Scoreboard bench for fibo_seq. A driver issues directed and
//                random computations and queues the expected result and due
//                cycle from a sequence-level reference model; a monitor pops
//                and compares on every done_tick. A second instance with
//                IW=6, FW=32 runs with start held high at index 47.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fibo_seq;

    typedef struct {
        logic [63:0] f;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        mode;
    logic [4:0]  i;
    logic        ready;
    logic        done_tick;
    logic        ovf;
    logic [19:0] f;

    logic        start_w;
    logic        mode_w;
    logic [5:0]  i_w;
    logic        ready_w;
    logic        done_tick_w;
    logic        ovf_w;
    logic [31:0] f_w;

    int   checks;
    int   failures;
    int   cyc;
    int   wide_cnt;
    exp_t q[$];

    fibo_seq #(.IW(5), .FW(20)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .i(i),
        .ready(ready), .done_tick(done_tick), .ovf(ovf), .f(f)
    );

    fibo_seq #(.IW(6), .FW(32)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .abort(1'b0), .mode(mode_w), .i(i_w),
        .ready(ready_w), .done_tick(done_tick_w), .ovf(ovf_w), .f(f_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: build the sequence term by term with wide arithmetic; the
    // first term that does not fit in fw bits ends the run early, saturated.
    function automatic void model(input bit md, input int idx, input int fw,
                                  output logic [63:0] ef, output logic eovf,
                                  output int lat);
        logic [63:0] seq [0:63];
        logic [63:0] lim;
        lim    = 64'd1 << fw;
        seq[0] = md ? 64'd2 : 64'd0;
        seq[1] = 64'd1;
        eovf   = 1'b0;
        if (idx <= 1) begin
            ef  = seq[idx];
            lat = 1;
            return;
        end
        for (int k = 2; k <= idx; k++) begin
            seq[k] = seq[k-1] + seq[k-2];
            if (seq[k] >= lim) begin
                ef   = lim - 64'd1;
                eovf = 1'b1;
                lat  = k - 1;
                return;
            end
        end
        ef  = seq[idx];
        lat = idx;
    endfunction

    // Monitor: every done_tick must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done_tick === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done_tick actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result_f", {44'd0, f}, e.f);
                chk("result_ovf", {63'd0, ovf}, {63'd0, e.ovf});
                chk("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        if (done_tick_w === 1'b1) begin
            wide_cnt++;
            chk("wide_f", {32'd0, f_w}, 64'd2971215073);
            chk("wide_ovf", {63'd0, ovf_w}, 64'd0);
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        while (ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("ready_timeout", {63'd0, ready}, 64'd1);
    endtask

    task automatic push_exp(input bit md, input int idx);
        exp_t e;
        int   lat;
        model(md, idx, 20, e.f, e.ovf, lat);
        e.due = cyc + 1 + lat;
        q.push_back(e);
    endtask

    // One computation; i and mode are scrambled while busy and must not matter.
    task automatic run(input bit md, input int idx);
        int t;
        wait_ready();
        start = 1'b1;
        mode  = md;
        i     = 5'(idx);
        push_exp(md, idx);
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (ready !== 1'b1 && t < 300) begin
            i    = 5'($urandom);
            mode = 1'($urandom);
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("run_timeout", {63'd0, ready}, 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev;
        checks   = 0;
        failures = 0;
        wide_cnt = 0;
        rst      = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        mode     = 1'b0;
        i        = '0;
        start_w  = 1'b1;
        mode_w   = 1'b0;
        i_w      = 6'd47;

        repeat (3) @(negedge clk);
        chk("reset_f", {44'd0, f}, 64'd0);
        chk("reset_ready", {63'd0, ready}, 64'd1);
        chk("reset_done", {63'd0, done_tick}, 64'd0);
        chk("reset_ovf", {63'd0, ovf}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed values
        run(1'b0, 5);
        repeat (2) @(negedge clk);
        chk("fib5_hold", {44'd0, f}, 64'd5);
        run(1'b0, 0);  chk("fib0", {44'd0, f}, 64'd0);
        run(1'b0, 1);  chk("fib1", {44'd0, f}, 64'd1);
        run(1'b1, 0);  chk("luc0", {44'd0, f}, 64'd2);
        run(1'b1, 5);  chk("luc5", {44'd0, f}, 64'd11);
        run(1'b0, 30); chk("fib30", {44'd0, f}, 64'd832040);
        chk("fib30_ovf", {63'd0, ovf}, 64'd0);
        run(1'b0, 31); chk("fib31", {44'd0, f}, 64'd1048575);
        chk("fib31_ovf", {63'd0, ovf}, 64'd1);
        run(1'b1, 28); chk("luc28", {44'd0, f}, 64'd710647);
        run(1'b1, 29); chk("luc29_ovf", {63'd0, ovf}, 64'd1);

        // Abort three cycles into a long run
        wait_ready();
        start = 1'b1;
        i     = 5'd20;
        mode  = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ready", {63'd0, ready}, 64'd1);
        run(1'b0, 6);  chk("after_abort_fib6", {44'd0, f}, 64'd8);

        // Reset in the middle of a computation
        wait_ready();
        start = 1'b1;
        i     = 5'd25;
        mode  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midreset_f", {44'd0, f}, 64'd0);
        chk("midreset_ovf", {63'd0, ovf}, 64'd0);
        chk("midreset_ready", {63'd0, ready}, 64'd1);
        chk("midreset_done", {63'd0, done_tick}, 64'd0);
        run(1'b0, 10); chk("fib10", {44'd0, f}, 64'd55);

        // start held high: back-to-back runs every 7 cycles
        wait_ready();
        start = 1'b1;
        mode  = 1'b0;
        i     = 5'd5;
        prev  = -1;
        for (int k = 0; k < 4; k++) begin
            wait_ready();
            push_exp(1'b0, 5);
            if (k > 0) chk("held_period", 64'(cyc + 1 - prev), 64'd7);
            prev = cyc + 1;
            @(negedge clk);
        end
        start = 1'b0;
        wait_ready();

        // Random traffic
        repeat (40) begin
            bit md;
            int idx;
            md  = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 31);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(md, idx);
        end

        repeat (3) @(negedge clk);
        chk("pending_expectations", 64'(q.size()), 64'd0);
        checks++;
        if (wide_cnt < 2) begin
            failures++;
            $display("FAIL wide_runs actual=%0d expected>=2", wide_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
